// File: rtl/decoder_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_scan_sequencer
//  Description : Upstream driver for a 2-to-4 line decoder. Produces the
//                select pair (A,B) and the active-low decoder enable.
//                Free-running scan steps through unmasked codes 0..3 with a
//                programmable dwell. Every code is preceded by a blanking gap
//                so decoder outputs never overlap. A req/ack one-shot mode
//                drives a single requested code for one dwell period.
//  Ports       :
//    clk         in   1        system clock, rising edge
//    rst_n       in   1        synchronous reset, active-low
//    scan_en     in   1        1 = continuous scan of unmasked codes
//    dwell       in   DWELL_W  active cycles per code (0 behaves as 1)
//    skip_mask   in   4        bit i = 1 skips code i during scan
//    req         in   1        one-shot request level, held until ack
//    req_addr    in   2        one-shot code
//    ack         out  1        1-cycle pulse, one-shot dwell complete
//    A           out  1        select MSB (code[1])
//    B           out  1        select LSB (code[0])
//    enable      out  1        decoder enable, active-low
//    busy        out  1        1 whenever not idle
//    frame_done  out  1        1-cycle pulse, last unmasked code finished
//  Revision    : 1.0  initial release
// ============================================================================
module decoder_scan_sequencer #(
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan_en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         skip_mask,
  input  logic               req,
  input  logic [1:0]         req_addr,
  output logic               ack,
  output logic               A,
  output logic               B,
  output logic               enable,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BLANK    = 3'd1;
  localparam logic [2:0] S_DWELL    = 3'd2;
  localparam logic [2:0] S_OS_BLANK = 3'd3;
  localparam logic [2:0] S_OS_DWELL = 3'd4;

  localparam logic [DWELL_W-1:0] C_BLANK_LOAD = DWELL_W'(BLANK_CYCLES - 1);

  logic [2:0]         state_q,      state_d;
  logic [DWELL_W-1:0] cnt_q,        cnt_d;
  logic [1:0]         code_q,       code_d;
  logic [1:0]         resume_q,     resume_d;
  logic               enable_q,     enable_d;
  logic               busy_q,       busy_d;
  logic               ack_q,        ack_d;
  logic               frame_done_q, frame_done_d;

  logic               ack_evt;
  logic               fd_evt;
  logic [1:0]         next_code;
  logic [1:0]         start_code;
  logic               mask_full;
  logic [DWELL_W-1:0] dwell_load;

  // First unmasked code at or after 'start', wrapping 3->0. With every
  // code masked it returns 'start'; callers gate on mask_full.
  function automatic logic [1:0] first_free(input logic [1:0] start,
                                            input logic [3:0] mask);
    logic [1:0] idx;
    first_free = start;
    // Descending so the nearest candidate is the one that sticks.
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (!mask[idx]) first_free = idx;
    end
  endfunction

  // True when 'c' is unmasked and every higher code is masked.
  function automatic logic is_last(input logic [1:0] c,
                                   input logic [3:0] mask);
    is_last = !mask[c];
    for (int k = 0; k < 4; k++) begin
      if (k > int'(c) && !mask[2'(k)]) is_last = 1'b0;
    end
  endfunction

  assign mask_full  = &skip_mask;
  assign next_code  = first_free(code_q + 2'd1, skip_mask);
  assign start_code = first_free(resume_q, skip_mask);
  // Counter holds remaining cycles minus one, so dwell of 0 or 1 both give one cycle.
  assign dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      code_q       <= 2'd0;
      resume_q     <= 2'd0;
      enable_q     <= 1'b1;
      busy_q       <= 1'b0;
      ack_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      resume_q     <= resume_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    resume_d = resume_q;
    ack_evt  = 1'b0;
    fd_evt   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_OS_BLANK;
          code_d  = req_addr;
          cnt_d   = C_BLANK_LOAD;
        end else if (scan_en && !mask_full) begin
          state_d = S_BLANK;
          code_d  = start_code;
          cnt_d   = C_BLANK_LOAD;
        end
      end

      S_BLANK, S_OS_BLANK: begin
        if (cnt_q == '0) begin
          state_d = (state_q == S_BLANK) ? S_DWELL : S_OS_DWELL;
          cnt_d   = dwell_load;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end

      S_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          fd_evt   = is_last(code_q, skip_mask);
          // Remember where the scan continues, whether or not it continues now.
          resume_d = next_code;
          if (req) begin
            state_d = S_OS_BLANK;
            code_d  = req_addr;
            cnt_d   = C_BLANK_LOAD;
          end else if (!scan_en || mask_full) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_BLANK;
            code_d  = next_code;
            cnt_d   = C_BLANK_LOAD;
          end
        end
      end

      S_OS_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          ack_evt = 1'b1;
          if (scan_en && !mask_full) begin
            state_d = S_BLANK;
            code_d  = start_code;
            cnt_d   = C_BLANK_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: outputs are registered versions of the next state, so
  // enable drops on the edge entering a dwell and rises on the edge leaving it,
  // while A/B only load on the edge entering a blank.
  always_comb begin
    enable_d     = !((state_d == S_DWELL) || (state_d == S_OS_DWELL));
    busy_d       = (state_d != S_IDLE);
    ack_d        = ack_evt;
    frame_done_d = fd_evt;
  end

  assign A          = code_q[1];
  assign B          = code_q[0];
  assign enable     = enable_q;
  assign busy       = busy_q;
  assign ack        = ack_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_scan_sequencer
//  Description : Directed bench for decoder_scan_sequencer. Expected dwell
//                windows (code, length) are queued when stimulus is applied
//                and popped when the DUT drives the corresponding window.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decoder_scan_sequencer;

  localparam int DWELL_W      = 16;
  localparam int BLANK_CYCLES = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               scan_en;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         skip_mask;
  logic               req;
  logic [1:0]         req_addr;
  logic               ack;
  logic               A;
  logic               B;
  logic               enable;
  logic               busy;
  logic               frame_done;

  typedef struct {
    logic [1:0] code;
    int         len;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  int cyc        = 0;
  int fd_cnt     = 0;
  int ack_cnt    = 0;
  int glitch_cnt = 0;
  int last_start = 0;
  logic [1:0] prev_ab;

  decoder_scan_sequencer #(
    .DWELL_W     (DWELL_W),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en),
    .dwell      (dwell),
    .skip_mask  (skip_mask),
    .req        (req),
    .req_addr   (req_addr),
    .ack        (ack),
    .A          (A),
    .B          (B),
    .enable     (enable),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Pulse counters and select-stability watch, sampled just after each edge.
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
    if (ack === 1'b1) ack_cnt = ack_cnt + 1;
    if (enable === 1'b0 && {A, B} !== prev_ab) glitch_cnt = glitch_cnt + 1;
    prev_ab = {A, B};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] c, input int l);
    exp_t e;
    e.code = c;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  // Waits for the next enable-low window, measures the gap before it and its
  // length, then checks both against the oldest queued expectation.
  task automatic take_dwell(input string tag, input int exp_gap);
    int         guard;
    int         n;
    logic [1:0] code;
    exp_t       e;
    guard = 0;
    while (enable !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    total++;
    assert (guard < 100) else begin
      bad++;
      $error("FAIL %s_start observed=%0d cycles expected=<100", tag, guard);
    end
    if (guard >= 100) return;
    if (exp_gap >= 0) chk({tag, "_gap"}, guard, exp_gap);
    code       = {A, B};
    last_start = cyc;
    n          = 0;
    while (enable === 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (exp_q.size() > 0) else begin
      bad++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk({tag, "_code"}, code, e.code);
    chk({tag, "_len"}, n, e.len);
  endtask

  initial begin
    int fd0;
    int ack0;
    int s0;

    // ---- reset ----
    rst_n     = 1'b0;
    scan_en   = 1'b0;
    dwell     = '0;
    skip_mask = 4'h0;
    req       = 1'b0;
    req_addr  = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_enable", enable, 1'b1);
    chk("rst_ab", {A, B}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_fd", frame_done, 1'b0);

    // ---- full scan 0,1,2,3,0 ----
    fd0       = fd_cnt;
    dwell     = 16'd4;
    scan_en   = 1'b1;
    rst_n     = 1'b1;
    push(2'd0, 4); push(2'd1, 4); push(2'd2, 4); push(2'd3, 4); push(2'd0, 4);
    take_dwell("scan0", BLANK_CYCLES + 1);
    s0 = last_start;
    take_dwell("scan1", BLANK_CYCLES);
    take_dwell("scan2", BLANK_CYCLES);
    take_dwell("scan3", BLANK_CYCLES);
    take_dwell("scan0b", BLANK_CYCLES);
    chk("scan_period", last_start - s0, 24);
    chk("scan_fd", fd_cnt - fd0, 1);
    scan_en = 1'b0;
    push(2'd1, 4);
    take_dwell("scan_stop", BLANK_CYCLES);
    chk("scan_stop_busy", busy, 1'b0);

    // ---- masked scan: only codes 1 and 3; resume pointer is 2 ----
    fd0       = fd_cnt;
    skip_mask = 4'b0101;
    scan_en   = 1'b1;
    push(2'd3, 4); push(2'd1, 4); push(2'd3, 4); push(2'd1, 4);
    take_dwell("mask_a", BLANK_CYCLES + 1);
    take_dwell("mask_b", BLANK_CYCLES);
    take_dwell("mask_c", BLANK_CYCLES);
    take_dwell("mask_d", BLANK_CYCLES);
    scan_en = 1'b0;
    push(2'd3, 4);
    take_dwell("mask_e", BLANK_CYCLES);
    chk("mask_fd", fd_cnt - fd0, 3);

    // ---- all masked: scan request is ignored ----
    skip_mask = 4'hF;
    scan_en   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("allmask_enable", enable, 1'b1);
      chk("allmask_busy", busy, 1'b0);
    end

    // ---- one-shot code 2, mask does not apply ----
    ack0     = ack_cnt;
    scan_en  = 1'b0;
    dwell    = 16'd3;
    req      = 1'b1;
    req_addr = 2'd2;
    push(2'd2, 3);
    take_dwell("os", BLANK_CYCLES + 1);
    chk("os_ack", ack, 1'b1);
    req = 1'b0;
    @(negedge clk);
    chk("os_ack_drop", ack, 1'b0);
    chk("os_idle", busy, 1'b0);
    chk("os_ack_count", ack_cnt - ack0, 1);

    // ---- pre-empt: resume pointer is 1, req for 3 arrives during code 1 ----
    ack0      = ack_cnt;
    fd0       = fd_cnt;
    skip_mask = 4'h0;
    dwell     = 16'd4;
    scan_en   = 1'b1;
    @(negedge clk);
    req      = 1'b1;
    req_addr = 2'd3;
    push(2'd1, 4); push(2'd3, 4);
    take_dwell("pre_c1", -1);
    take_dwell("pre_os3", BLANK_CYCLES);
    chk("pre_ack", ack, 1'b1);
    req = 1'b0;
    push(2'd2, 4); push(2'd3, 4);
    take_dwell("pre_resume2", BLANK_CYCLES);
    take_dwell("pre_resume3", BLANK_CYCLES);
    chk("pre_ack_count", ack_cnt - ack0, 1);
    chk("pre_fd", fd_cnt - fd0, 1);

    // ---- dwell of 0 gives a single active cycle ----
    dwell = 16'd0;
    push(2'd0, 1);
    take_dwell("dwell0", BLANK_CYCLES);

    // ---- reset in the middle of a dwell ----
    dwell = 16'd5;
    for (int i = 0; i < 20 && enable !== 1'b0; i++) @(negedge clk);
    chk("mid_in_dwell", enable, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_enable", enable, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ab", {A, B}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    dwell = 16'd2;
    // resume pointer was cleared, so scan restarts at code 0
    push(2'd0, 2);
    take_dwell("post_rst0", BLANK_CYCLES + 1);
    scan_en = 1'b0;
    push(2'd1, 2);
    take_dwell("post_rst1", BLANK_CYCLES);
    chk("post_rst_idle", busy, 1'b0);

    chk("select_stable", glitch_cnt, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
